// File: rtl/mips_dev_pkg.sv
// Shared MIPS device definitions: bridge slot bases, timer register map,
// CTRL bit positions, MODE encodings and timer FSM state encoding.
package mips_dev_pkg;

  localparam logic [31:0] TMR_SLOT1_BASE = 32'h0000_7f00;
  localparam logic [31:0] TMR_SLOT2_BASE = 32'h0000_7f10;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam int CTRL_EN = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tmr_state_e;

endpackage

// File: rtl/mips_timer_prescaler.sv
// Count-enable divider for mips_timer: tick is high one clk in every DIV.
// clr restarts the division so a fresh CTRL write gets a full period.
module mips_timer_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mips_timer.sv
// Programmable countdown timer slot (CTRL/PRESET/COUNT), one-shot or reload.
// Define MIPS_TIMER_PRESCALE_EN to advance the FSM every PRESCALE_DIV clocks.
module mips_timer
  import mips_dev_pkg::*;
#(
  parameter int unsigned PRESCALE_DIV = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_q, irq_d;
  tmr_state_e  state_q, state_d;

  logic ctrl_wr;
  logic preset_wr;
  logic tick;
  logic reload;

  wire unused_addr = ^Addr[31:4];

  assign ctrl_wr   = WE && (Addr[3:2] == REG_CTRL);
  assign preset_wr = WE && (Addr[3:2] == REG_PRESET);
  assign reload    = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);

`ifdef MIPS_TIMER_PRESCALE_EN
  mips_timer_prescaler #(
    .DIV (PRESCALE_DIV)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (ctrl_wr),
    .tick    (tick)
  );
`else
  localparam int unsigned UNUSED_DIV = PRESCALE_DIV;
  assign tick = 1'b1;
`endif

  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    irq_d    = irq_q;
    state_d  = state_q;
    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (ctrl_q[CTRL_EN]) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          count_d = preset_q;
          state_d = ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl_q[CTRL_EN]) begin
            state_d = ST_IDLE;
          end else if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin
            count_d = '0;
            irq_d   = 1'b1;
            state_d = ST_INT;
          end
        end
        ST_INT: begin
          if (reload) begin
            irq_d   = 1'b0;
            state_d = ST_LOAD;
          end else begin
            ctrl_d[CTRL_EN] = 1'b0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Bus writes take priority over anything the FSM did this edge.
    if (ctrl_wr) begin
      ctrl_d = Din[3:0];
      irq_d  = 1'b0;
    end
    if (preset_wr) preset_d = Din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      irq_q    <= 1'b0;
      state_q  <= ST_IDLE;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
      state_q  <= state_d;
    end
  end

  always_comb begin
    Dout = '0;
    unique case (Addr[3:2])
      REG_CTRL:   Dout = {28'd0, ctrl_q};
      REG_PRESET: Dout = preset_q;
      REG_COUNT:  Dout = count_q;
      default:    Dout = '0;
    endcase
  end

  assign IRQ = irq_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_mips_timer.sv
// Directed bench for mips_timer: reset, one-shot, reload, mask/halt, bus edges.
// Default build (no prescaler); each step checked with immediate assertions.
module tb_mips_timer;
  import mips_dev_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:2] Addr = '0;
  logic        WE = 1'b0;
  logic [31:0] Din = '0;
  logic [31:0] Dout;
  logic        IRQ;

  int total = 0;
  int bad = 0;

  localparam logic [29:0] BASE_W = 30'(TMR_SLOT1_BASE >> 2);

  mips_timer #(
    .PRESCALE_DIV (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .Addr    (Addr),
    .WE      (WE),
    .Din     (Din),
    .Dout    (Dout),
    .IRQ     (IRQ)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] idx, output logic [31:0] v);
    Addr = BASE_W + 30'(idx);
    #1;
    v = Dout;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] idx,
                         input logic [31:0] exp);
    logic [31:0] v;
    rd(idx, v);
    chk(tag, v, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    chk(tag, {31'd0, IRQ}, {31'd0, exp});
  endtask

  task automatic wr(input logic [1:0] idx, input logic [31:0] data);
    Addr = BASE_W + 30'(idx);
    Din  = data;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE   = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] v;
    bit seen2;
    bit saw_reload;

    // power-on reset
    #2 reset_n = 1'b0;
    #1;
    chk_reg("por_ctrl", REG_CTRL, 32'h0);
    chk_reg("por_preset", REG_PRESET, 32'h0);
    chk_reg("por_count", REG_COUNT, 32'h0);
    chk_irq("por_irq", 1'b0);
    cyc(1);
    reset_n = 1'b1;
    cyc(1);

    // one-shot, PRESET=3, CTRL=EN|IM
    wr(REG_PRESET, 32'd3);
    wr(REG_CTRL, 32'h9);
    cyc(2);
    chk_reg("os_cnt_e2", REG_COUNT, 32'd3);
    cyc(1);
    chk_reg("os_cnt_e3", REG_COUNT, 32'd2);
    cyc(1);
    chk_reg("os_cnt_e4", REG_COUNT, 32'd1);
    chk_irq("os_irq_e4", 1'b0);
    cyc(1);
    chk_reg("os_cnt_e5", REG_COUNT, 32'd0);
    chk_irq("os_irq_e5", 1'b1);
    cyc(1);
    chk_reg("os_ctrl_e6", REG_CTRL, 32'h8);
    chk_irq("os_irq_e6", 1'b1);
    cyc(3);
    chk_irq("os_irq_held", 1'b1);
    wr(REG_CTRL, 32'h8);
    chk_irq("os_irq_clr", 1'b0);
    cyc(2);

    // auto-reload, PRESET=2, CTRL=EN|reload|IM
    wr(REG_PRESET, 32'd2);
    wr(REG_CTRL, 32'hB);
    cyc(3);
    chk_irq("ar_irq_e3", 1'b0);
    cyc(1);
    chk_irq("ar_irq_e4", 1'b1);
    chk_reg("ar_cnt_e4", REG_COUNT, 32'd0);
    cyc(1);
    chk_irq("ar_pulse_w1", 1'b0);
    seen2 = 1'b0;
    saw_reload = 1'b0;
    for (int i = 0; i < 10 && !seen2; i++) begin
      cyc(1);
      rd(REG_COUNT, v);
      if (v == 32'd2) saw_reload = 1'b1;
      if (IRQ) seen2 = 1'b1;
    end
    chk("ar_second_pulse", {31'd0, seen2}, 32'd1);
    chk("ar_reload_seen", {31'd0, saw_reload}, 32'd1);
    cyc(1);
    chk_irq("ar_pulse_w2", 1'b0);
    chk_reg("ar_ctrl_kept", REG_CTRL, 32'hB);
    wr(REG_CTRL, 32'h0);
    cyc(6);

    // masked: IRQ stays low, one-shot still clears EN
    wr(REG_PRESET, 32'd2);
    wr(REG_CTRL, 32'h1);
    cyc(2);
    chk_reg("mk_cnt_e2", REG_COUNT, 32'd2);
    cyc(2);
    chk_reg("mk_cnt_e4", REG_COUNT, 32'd0);
    chk_irq("mk_irq_e4", 1'b0);
    cyc(1);
    chk_reg("mk_ctrl_e5", REG_CTRL, 32'h0);
    chk_irq("mk_irq_e5", 1'b0);
    cyc(2);

    // halt mid-count freezes COUNT
    wr(REG_PRESET, 32'd5);
    wr(REG_CTRL, 32'h1);
    cyc(3);
    chk_reg("ht_cnt_e3", REG_COUNT, 32'd4);
    wr(REG_CTRL, 32'h0);
    chk_reg("ht_cnt_e4", REG_COUNT, 32'd3);
    cyc(4);
    chk_reg("ht_frozen", REG_COUNT, 32'd3);

    // re-enable reloads from PRESET, then reset at COUNT=5
    wr(REG_CTRL, 32'h9);
    cyc(2);
    chk_reg("re_cnt_e2", REG_COUNT, 32'd5);
    #3 reset_n = 1'b0;
    #1;
    chk_reg("rst_ctrl", REG_CTRL, 32'h0);
    chk_reg("rst_preset", REG_PRESET, 32'h0);
    chk_reg("rst_count", REG_COUNT, 32'h0);
    chk_irq("rst_irq", 1'b0);
    cyc(1);
    reset_n = 1'b1;
    cyc(1);

    // bus edges
    wr(REG_COUNT, 32'h1234);
    chk_reg("be_count_ro", REG_COUNT, 32'h0);
    wr(2'd3, 32'hDEAD);
    chk_reg("be_off_c", 2'd3, 32'h0);
    chk_reg("be_preset_kept", REG_PRESET, 32'h0);
    chk_reg("be_ctrl_kept", REG_CTRL, 32'h0);

    // high CTRL bits ignored; PRESET=0 acts like 1
    wr(REG_CTRL, 32'hFFFF_FFF9);
    chk_reg("be_ctrl_mask", REG_CTRL, 32'h9);
    cyc(2);
    chk_irq("p0_irq_e2", 1'b0);
    chk_reg("p0_cnt_e2", REG_COUNT, 32'h0);
    cyc(1);
    chk_irq("p0_irq_e3", 1'b1);
    wr(REG_CTRL, 32'h0);
    chk_irq("p0_irq_clr", 1'b0);
    cyc(2);

    // PRESET write does not disturb a running count
    wr(REG_PRESET, 32'd4);
    wr(REG_CTRL, 32'h1);
    cyc(2);
    chk_reg("pw_cnt_e2", REG_COUNT, 32'd4);
    wr(REG_PRESET, 32'd9);
    chk_reg("pw_cnt_e3", REG_COUNT, 32'd3);
    cyc(1);
    chk_reg("pw_cnt_e4", REG_COUNT, 32'd2);
    chk_reg("pw_preset", REG_PRESET, 32'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
